// File: rtl/ext_dev_pkg.sv
// Shared constants and types for the external-device
// (7-segment display) write path.
package ext_dev_pkg;

  localparam logic [5:0] EXDEV_OPCODE  = 6'h3F;
  localparam int         DIG_DP_BIT    = 4;
  localparam int         DIG_BLANK_BIT = 5;

  typedef logic [5:0] digit_t;
  typedef logic [6:0] seg7_t;
  typedef logic [1:0] dig_idx_t;

  localparam digit_t DIG_RESET = 6'h20;
  localparam seg7_t  SEG_OFF   = 7'h7F;

endpackage

// File: rtl/ext_display_ctrl_if.sv
// MEM-stage external-write bus into the display controller.
// Carries the write strobe, digit select, data and the ack.
interface ext_display_ctrl_if;
  import ext_dev_pkg::*;

  logic     ExWrite;
  dig_idx_t ExAno;
  logic [7:0] ExData;
  logic     wr_ack;

  modport master (
    output ExWrite,
    output ExAno,
    output ExData,
    input  wr_ack
  );

  modport slave (
    input  ExWrite,
    input  ExAno,
    input  ExData,
    output wr_ack
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low gfedcba segment pattern.
module hex_to_seg7
  import ext_dev_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ext_display_ctrl.sv
// 4-digit 7-segment scan controller with per-digit storage,
// inter-digit blanking and a registered write acknowledge.
module ext_display_ctrl
  import ext_dev_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  ext_display_ctrl_if.slave   bus,
  input  logic                disp_en,
  output logic [3:0]          an,
  output seg7_t               seg,
  output logic                dp
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] prescaler_q, prescaler_d;
  dig_idx_t      idx_q, idx_d;
  digit_t [3:0]  digit_q, digit_d;
  logic          ack_q, ack_d;
  logic [3:0]    an_q, an_d;
  seg7_t         seg_q, seg_d;
  logic          dp_q, dp_d;

  digit_t        cur;
  seg7_t         seg_lut;
  logic          wrap;
  logic          unused_data;

  assign unused_data = ^bus.ExData[7:6];

  assign cur  = digit_q[idx_q];
  assign wrap = (prescaler_q == PW'(SCAN_DIV - 1));

  hex_to_seg7 u_hex (
    .hex (cur[3:0]),
    .seg (seg_lut)
  );

  always_comb begin
    prescaler_d = wrap ? '0 : prescaler_q + 1'b1;
    idx_d       = wrap ? idx_q + 1'b1 : idx_q;
    digit_d     = digit_q;
    if (bus.ExWrite)
      digit_d[bus.ExAno] = bus.ExData[5:0];
    ack_d = bus.ExWrite;
  end

  // Output stage looks at the state already registered, so a
  // write to the lit digit shows up one cycle after its edge.
  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_lut;
    dp_d  = ~cur[DIG_DP_BIT];
    if (!disp_en ||
        (prescaler_q < PW'(BLANK_CYCLES)) ||
        cur[DIG_BLANK_BIT])
      an_d = 4'hF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      digit_q     <= {4{DIG_RESET}};
      ack_q       <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      digit_q     <= digit_d;
      ack_q       <= ack_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.wr_ack = ack_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_ext_display_ctrl.sv
// Randomized bench for ext_display_ctrl against a
// cycle-count based reference model.
module tb_ext_display_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  ext_display_ctrl_if bus ();

  ext_display_ctrl #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .disp_en (disp_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [5:0] m_dig [4];
  int n;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 6'h20;
  endtask

  // Model: after n edges since reset, prescaler = n mod SD,
  // displayed digit = (n div SD) mod 4.
  task automatic cycle(input bit we, input int ano,
                       input logic [7:0] data, input bit en);
    int pre, idx;
    logic [5:0] dg;
    logic [3:0] one, e_an;
    logic [6:0] e_seg;
    logic e_dp;
    bus.ExWrite = we;
    bus.ExAno   = 2'(ano);
    bus.ExData  = data;
    disp_en     = en;
    @(posedge clk);
    pre = n % SD;
    idx = (n / SD) % 4;
    dg  = m_dig[idx];
    one = 4'b0001;
    if (!en || pre < BC || dg[5]) e_an = 4'hF;
    else e_an = ~(one << idx);
    e_seg = hex_tab[dg[3:0]];
    e_dp  = ~dg[4];
    if (we) m_dig[ano] = data[5:0];
    n++;
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("wr_ack", 32'(bus.wr_ack), 32'(we));
  endtask

  task automatic idle(input int k, input bit en);
    for (int i = 0; i < k; i++) cycle(1'b0, 0, 8'h00, en);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ack", 32'(bus.wr_ack), 32'h0);
    #20;
    @(negedge clk);
    bus.ExWrite = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset       = 1'b0;
    bus.ExWrite = 1'b0;
    bus.ExAno   = 2'd0;
    bus.ExData  = 8'h00;
    disp_en     = 1'b1;
    #2;
    do_reset();

    idle(40, 1'b1);

    cycle(1'b1, 0, 8'h05, 1'b1);
    idle(40, 1'b1);

    cycle(1'b1, 0, 8'h01, 1'b1);
    cycle(1'b1, 1, 8'h1A, 1'b1);
    cycle(1'b1, 2, 8'h0F, 1'b1);
    cycle(1'b1, 3, 8'h08, 1'b1);
    idle(40, 1'b1);

    while ((n % 32) != 4) cycle(1'b0, 0, 8'h00, 1'b1);
    cycle(1'b1, 0, 8'h03, 1'b1);
    idle(3, 1'b1);

    idle(20, 1'b0);
    idle(20, 1'b1);

    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) == 0,
            int'($urandom_range(0, 3)),
            8'($urandom),
            $urandom_range(0, 9) != 0);

    cycle(1'b1, 2, 8'h07, 1'b1);
    bus.ExWrite = 1'b1;
    bus.ExAno   = 2'd1;
    bus.ExData  = 8'h09;
    #2;
    do_reset();
    idle(40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
